display_spi_loader: RTL
=======================

Name: display_spi_loader

Overview:
- SPI-mode-0 slave that receives frame data from the host MCU and writes 24-bit pixels into the back buffer of display_memory through its wen/wrow/wcol/wdata write port.
- Drives the display_memory flip input to swap front and back buffers on host command.
- Sits directly upstream of display_memory in the display-controller top, in the clk_disp domain.

Parameters:
- rows, 8, panel rows addressed per buffer
- columns, 32, panel columns
- width, 24, pixel width in bits; fixed at 24 (R,G,B bytes)

Ports:
- clk  input  1  display clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock from host, asynchronous to clk
- mosi  input  1  SPI data, MSB first
- cs_n  input  1  SPI chip select, active low
- wen  output  1  one-cycle write strobe to display_memory
- wrow  output  clog2(rows)  write row address
- wcol  output  clog2(columns)  write column address
- wdata  output  width  pixel {B[23:16],G[15:8],R[7:0]}; matches the encoder's rgb[0]=red ordering
- flip  output  1  buffer-select level; toggles on each committed flip command
- busy  output  1  high while cs_n is low (synchronized)
- overrun  output  1  sticky: pixel bytes received past the last address

Behaviour:
- Reset (rst=0):
  - All outputs are 0.
  - State is IDLE.
  - Bit, byte and address counters are 0.
  - Synchronizer flops are preset to sclk=0, mosi=0, cs_n=1.
- Synchronization:
  - sclk, mosi and cs_n each pass through 2-flop synchronizers.
  - A rising edge of sclk is detected when the synchronized value is 1 and its previous registered value is 0.
  - mosi is sampled in the edge-detect cycle.
  - clk must be ≥ 4× sclk.
- Bit assembly:
  - A 3-bit counter and an 8-bit shift register, shifting MSB first.
  - A byte completes on the 8th sampled edge.
  - A byte is valid only while synchronized cs_n=0.
- States:
  - IDLE: a synchronized cs_n falling edge clears the bit counter and goes to CMD.
  - CMD: the first byte selects the next state.
    - 0x01: clear wrow/wcol to 0, go to PIX_R.
    - 0x02: set flip_pending, go to DRAIN.
    - Any other value: go to DRAIN.
  - PIX_R / PIX_G / PIX_B: each byte is stored in its field.
    - Completion of the B byte asserts wen for exactly one clk cycle, registered the cycle after the edge-detect cycle.
    - wrow/wcol/wdata are stable during that cycle.
    - The address advances the cycle after wen: wcol increments; at columns-1 it wraps to 0 and wrow increments.
    - After writing the pixel at (rows-1, columns-1), go to DRAIN with no wrap to 0.
    - Otherwise go to PIX_R.
  - DRAIN: completed bytes are ignored. If the previous command was 0x01 and a byte completes, set overrun (sticky until reset).
- Synchronized cs_n rising edge, from any state:
  - Return to IDLE and discard any partial byte or partial pixel; no wen is issued.
  - If flip_pending, toggle flip in that same cycle and clear flip_pending.
- busy equals the inverse of synchronized cs_n.
- Async reset mid-transfer aborts everything immediately. flip returns to 0, so both the loader and display_memory restart on buffer 0.
- wen and the flip toggle never occur in the same cycle, because a flip is only committed on cs_n deassertion.

Test Plan:
- Reset with cs_n=1 → all outputs 0. Release reset → outputs remain 0 with no wen.
- cs_n low, bytes 0x01,0x11,0x22,0x33, cs_n high → one wen pulse with wrow=0, wcol=0, wdata=0x332211; no further wen.
- Command 0x01 followed by 256 pixels (pixel n = {n,n,n}) → 256 wen pulses.
  - Pulse 32 has wrow=1, wcol=0.
  - The last pulse has wrow=7, wcol=31, wdata=0xFFFFFF.
  - overrun stays 0.
  - Sending one more byte after the last pixel sets overrun=1.
- cs_n low, 0x02, cs_n high, done twice → flip goes 0→1 on the first cs_n rise and 1→0 on the second; no wen during either.
- 0x01,0xAA,0xBB then cs_n high after 4 bits of the third byte → no wen. A fresh 0x01 transfer then writes the next pixel at (0,0).
- Assert rst during the B byte of the 5th pixel → wen is never asserted for it. After release, flip=0, overrun=0, and the next frame starts at (0,0).

Source files
------------

// File: rtl/display_spi_loader.sv
// SPI mode-0 slave that turns host frame bytes into 24-bit pixel writes for
// display_memory's back buffer and commits buffer flips when chip select drops away.
module display_spi_loader #(
  parameter int rows    = 8,
  parameter int columns = 32,
  parameter int width   = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       mosi,
  input  logic                       cs_n,
  output logic                       wen,
  output logic [$clog2(rows)-1:0]    wrow,
  output logic [$clog2(columns)-1:0] wcol,
  output logic [width-1:0]           wdata,
  output logic                       flip,
  output logic                       busy,
  output logic                       overrun
);

  localparam int RW = $clog2(rows);
  localparam int CW = $clog2(columns);

  typedef enum logic [2:0] {IDLE, CMD, PIX_R, PIX_G, PIX_B, DRAIN} state_t;

  logic sclkMeta_q, sclkSync_q, sclkPrev_q;
  logic mosiMeta_q, mosiSync_q;
  logic csMeta_q, csSync_q, csPrev_q;

  state_t          state_q, state_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      red_q, red_d, green_q, green_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic            wen_q, wen_d;
  logic [RW-1:0]   wrow_q, wrow_d;
  logic [CW-1:0]   wcol_q, wcol_d;
  logic            flip_q, flip_d;
  logic            flipPending_q, flipPending_d;
  logic            overrun_q, overrun_d;
  logic            cmdPix_q, cmdPix_d;

  logic       sclkRise, csFall, csRise, bitAccept, byteDone, lastAddr;
  logic [7:0] byteVal;

  // Sync flops come out of reset as an idle bus: clock low, data low, deselected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclkMeta_q <= 1'b0;
      sclkSync_q <= 1'b0;
      sclkPrev_q <= 1'b0;
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
      csMeta_q   <= 1'b1;
      csSync_q   <= 1'b1;
      csPrev_q   <= 1'b1;
    end else begin
      sclkMeta_q <= sclk;
      sclkSync_q <= sclkMeta_q;
      sclkPrev_q <= sclkSync_q;
      mosiMeta_q <= mosi;
      mosiSync_q <= mosiMeta_q;
      csMeta_q   <= cs_n;
      csSync_q   <= csMeta_q;
      csPrev_q   <= csSync_q;
    end
  end

  assign sclkRise  = sclkSync_q & ~sclkPrev_q;
  assign csFall    = ~csSync_q & csPrev_q;
  assign csRise    = csSync_q & ~csPrev_q;
  assign bitAccept = sclkRise & ~csSync_q & (state_q != IDLE);
  assign byteVal   = {shift_q[6:0], mosiSync_q};
  assign byteDone  = bitAccept & (bitCnt_q == 3'd7);
  assign lastAddr  = (wrow_q == RW'(rows - 1)) && (wcol_q == CW'(columns - 1));

  always_comb begin
    state_d       = state_q;
    bitCnt_d      = bitCnt_q;
    shift_d       = shift_q;
    red_d         = red_q;
    green_d       = green_q;
    wdata_d       = wdata_q;
    wen_d         = 1'b0;
    wrow_d        = wrow_q;
    wcol_d        = wcol_q;
    flip_d        = flip_q;
    flipPending_d = flipPending_q;
    overrun_d     = overrun_q;
    cmdPix_d      = cmdPix_q;

    if (bitAccept) begin
      shift_d  = byteVal;
      bitCnt_d = bitCnt_q + 3'd1;
    end

    // The address moves on the cycle after the strobe so the write sees stable inputs.
    if (wen_q && !lastAddr) begin
      if (wcol_q == CW'(columns - 1)) begin
        wcol_d = '0;
        wrow_d = wrow_q + RW'(1);
      end else begin
        wcol_d = wcol_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (csFall) begin
          bitCnt_d = 3'd0;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (byteDone) begin
          cmdPix_d = 1'b0;
          state_d  = DRAIN;
          if (byteVal == 8'h01) begin
            wrow_d   = '0;
            wcol_d   = '0;
            cmdPix_d = 1'b1;
            state_d  = PIX_R;
          end else if (byteVal == 8'h02) begin
            flipPending_d = 1'b1;
          end
        end
      end
      PIX_R: begin
        if (byteDone) begin
          red_d   = byteVal;
          state_d = PIX_G;
        end
      end
      PIX_G: begin
        if (byteDone) begin
          green_d = byteVal;
          state_d = PIX_B;
        end
      end
      PIX_B: begin
        if (byteDone) begin
          wdata_d = {byteVal, green_q, red_q};
          wen_d   = 1'b1;
          state_d = lastAddr ? DRAIN : PIX_R;
        end
      end
      DRAIN: begin
        if (byteDone && cmdPix_q) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Deselect wins over everything and is the only point a flip is committed.
    if (csRise) begin
      state_d  = IDLE;
      bitCnt_d = 3'd0;
      wen_d    = 1'b0;
      if (flipPending_q) begin
        flip_d        = ~flip_q;
        flipPending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bitCnt_q      <= 3'd0;
      shift_q       <= 8'd0;
      red_q         <= 8'd0;
      green_q       <= 8'd0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      wrow_q        <= '0;
      wcol_q        <= '0;
      flip_q        <= 1'b0;
      flipPending_q <= 1'b0;
      overrun_q     <= 1'b0;
      cmdPix_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitCnt_q      <= bitCnt_d;
      shift_q       <= shift_d;
      red_q         <= red_d;
      green_q       <= green_d;
      wdata_q       <= wdata_d;
      wen_q         <= wen_d;
      wrow_q        <= wrow_d;
      wcol_q        <= wcol_d;
      flip_q        <= flip_d;
      flipPending_q <= flipPending_d;
      overrun_q     <= overrun_d;
      cmdPix_q      <= cmdPix_d;
    end
  end

  assign wen     = wen_q;
  assign wrow    = wrow_q;
  assign wcol    = wcol_q;
  assign wdata   = wdata_q;
  assign flip    = flip_q;
  assign busy    = ~csSync_q;
  assign overrun = overrun_q;

endmodule
